// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Dynamic branch direction predictor. A table of 2-bit saturating
//            counters indexed by fetch PC produces a registered predicted-taken
//            bit for the instruction entering ID. The table is trained by the
//            resolved outcome from ID, and branch / mispredict statistics
//            are kept in saturating counters.
//            Optional gshare indexing is enabled by defining BP_GSHARE_EN:
//            the lookup index is XORed with a global history register that
//            shifts in each resolved outcome.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int PC_W       = 64,
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  if_valid,
  input  logic [PC_W-1:0]       if_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_pred,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispred_cnt
);

  localparam int              C_ENTRIES   = 1 << INDEX_BITS;
  localparam logic [1:0]      C_CNT_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0]      C_CNT_MAX   = 2'b11;
  localparam logic [1:0]      C_CNT_MIN   = 2'b00;
  localparam logic [CNT_W-1:0] C_STAT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_STAT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]            cnt_q [C_ENTRIES];
  logic [1:0]            cnt_upd_d;
  logic                  pred_taken_q, pred_taken_d;
  logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
  logic [CNT_W-1:0]      branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]      mispred_cnt_q, mispred_cnt_d;

  // --------------------------------------------------------------------------
  // Lookup index
  // --------------------------------------------------------------------------
  // PCs are word aligned, so the two low bits never select an entry; upper
  // PC bits alias onto the same entries since there is no tag.
  logic [INDEX_BITS-1:0]      pc_idx;
  logic [INDEX_BITS-1:0]      lookup_idx;
  logic [1:0]                 rd_cnt;
  logic [PC_W-INDEX_BITS-1:0] unused_pc_bits;

  assign pc_idx         = if_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = {if_pc[PC_W-1:INDEX_BITS+2], if_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  // Global history shifts in every resolved outcome, newest in bit 0.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) begin
      ghr_d = {ghr_q[INDEX_BITS-2:0], upd_taken};
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // The lookup uses the history as it stood before this cycle's update.
  assign lookup_idx = pc_idx ^ ghr_q;
`else
  assign lookup_idx = pc_idx;
`endif

  // Table read is combinational and sees the pre-update value of the entry,
  // so a same-cycle write to that entry is only visible from the next cycle.
  assign rd_cnt = cnt_q[lookup_idx];

  // --------------------------------------------------------------------------
  // Counter table training
  // --------------------------------------------------------------------------
  // Saturating step of the entry being trained; never wraps past 00 or 11.
  always_comb begin
    cnt_upd_d = cnt_q[upd_index];
    if (upd_taken) begin
      if (cnt_q[upd_index] != C_CNT_MAX) begin
        cnt_upd_d = cnt_q[upd_index] + 2'd1;
      end
    end else begin
      if (cnt_q[upd_index] != C_CNT_MIN) begin
        cnt_upd_d = cnt_q[upd_index] - 2'd1;
      end
    end
  end

  // Table storage; training ignores stall/flush so a resolved branch always
  // leaves its mark even in a bubbled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_ENTRIES; i++) begin
        cnt_q[i] <= C_CNT_RESET;
      end
    end else if (upd_valid) begin
      cnt_q[upd_index] <= cnt_upd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Prediction register
  // --------------------------------------------------------------------------
  // Flush beats stall; a stall holds; an invalid fetch still records the
  // index but never predicts taken.
  always_comb begin
    pred_taken_d = pred_taken_q;
    pred_index_d = pred_index_q;
    if (flush_i) begin
      pred_taken_d = 1'b0;
      pred_index_d = '0;
    end else if (!stall_i) begin
      pred_index_d = lookup_idx;
      pred_taken_d = if_valid & rd_cnt[1];
    end
  end

  // Prediction registers travelling with the instruction into ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
    end else begin
      pred_taken_q <= pred_taken_d;
      pred_index_q <= pred_index_d;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid) begin
      if (branch_cnt_q != C_STAT_MAX) begin
        branch_cnt_d = branch_cnt_q + C_STAT_ONE;
      end
      if ((upd_taken != upd_pred) && (mispred_cnt_q != C_STAT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + C_STAT_ONE;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pred_taken  = pred_taken_q;
  assign pred_index  = pred_index_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Self-checking bench for branch_predictor. A default instance and
//            a CNT_W=4 instance share stimulus; a reference model pushes the
//            expected outputs of every cycle to a queue that is popped after
//            the edge, and table rows carry hand-derived spot values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int PC_W = 64;
  localparam int IB   = 4;
  localparam int CW   = 32;
  localparam int CWS  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, stall_i, flush_i, if_valid;
  logic [63:0]   if_pc;
  logic          upd_valid, upd_taken, upd_pred;
  logic [IB-1:0] upd_index;

  logic          pred_taken, pred_taken_s;
  logic [IB-1:0] pred_index, pred_index_s;
  logic [CW-1:0] branch_cnt, mispred_cnt;
  logic [CWS-1:0] branch_cnt_s, mispred_cnt_s;

  branch_predictor #(.PC_W(PC_W), .INDEX_BITS(IB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_index(pred_index),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken), .upd_pred(upd_pred),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predictor #(.PC_W(PC_W), .INDEX_BITS(IB), .CNT_W(CWS)) dut_s (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken_s), .pred_index(pred_index_s),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken), .upd_pred(upd_pred),
    .branch_cnt(branch_cnt_s), .mispred_cnt(mispred_cnt_s)
  );

  typedef struct {
    logic          rst, stall, flush, ifv;
    logic [63:0]   pc;
    logic          uv;
    logic [IB-1:0] ui;
    logic          ut, up;
    logic          chk;
    logic          e_t;
    logic [IB-1:0] e_i;
    int            e_b, e_m;
  } vec_t;

  typedef struct {
    logic           t;
    logic [IB-1:0]  i;
    logic [CW-1:0]  b, m;
    logic [CWS-1:0] bs, ms;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state.
  logic [1:0]     m_tbl [16];
  logic           m_pt;
  logic [IB-1:0]  m_pi;
  logic [CW-1:0]  m_b, m_m;
  logic [CWS-1:0] m_bs, m_ms;
`ifdef BP_GSHARE_EN
  logic [IB-1:0]  m_ghr;
`endif

  function automatic vec_t mk(bit r, bit st, bit fl, bit iv, logic [63:0] pc,
                              bit uv, logic [IB-1:0] ui, bit ut, bit up,
                              bit chk, bit et, logic [IB-1:0] ei, int eb, int em);
    vec_t v;
    v.rst = r; v.stall = st; v.flush = fl; v.ifv = iv; v.pc = pc;
    v.uv = uv; v.ui = ui; v.ut = ut; v.up = up;
    v.chk = chk; v.e_t = et; v.e_i = ei; v.e_b = eb; v.e_m = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one edge and queue what the DUT must show after it.
  task automatic model_step(input vec_t v);
    exp_t e;
    logic [IB-1:0] idx;
    if (v.rst) begin
      for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
      m_pt = 1'b0; m_pi = '0; m_b = '0; m_m = '0; m_bs = '0; m_ms = '0;
`ifdef BP_GSHARE_EN
      m_ghr = '0;
`endif
    end else begin
      idx = v.pc[5:2];
`ifdef BP_GSHARE_EN
      idx = idx ^ m_ghr;
`endif
      if (v.flush) begin
        m_pt = 1'b0; m_pi = '0;
      end else if (!v.stall) begin
        m_pi = idx;
        m_pt = v.ifv ? m_tbl[idx][1] : 1'b0;
      end
      if (v.uv) begin
        if (v.ut && m_tbl[v.ui] != 2'b11) m_tbl[v.ui] = m_tbl[v.ui] + 2'd1;
        if (!v.ut && m_tbl[v.ui] != 2'b00) m_tbl[v.ui] = m_tbl[v.ui] - 2'd1;
        if (m_b != 32'hFFFF_FFFF) m_b = m_b + 32'd1;
        if (m_bs != 4'hF) m_bs = m_bs + 4'd1;
        if (v.ut != v.up) begin
          if (m_m != 32'hFFFF_FFFF) m_m = m_m + 32'd1;
          if (m_ms != 4'hF) m_ms = m_ms + 4'd1;
        end
`ifdef BP_GSHARE_EN
        m_ghr = {m_ghr[IB-2:0], v.ut};
`endif
      end
    end
    e.t = m_pt; e.i = m_pi; e.b = m_b; e.m = m_m; e.bs = m_bs; e.ms = m_ms;
    exp_q.push_back(e);
  endtask

  // Drive one cycle, then compare after the edge against the scoreboard and,
  // where the row asks for it, the hand-derived values.
  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    rst = v.rst; stall_i = v.stall; flush_i = v.flush; if_valid = v.ifv;
    if_pc = v.pc; upd_valid = v.uv; upd_index = v.ui;
    upd_taken = v.ut; upd_pred = v.up;
    model_step(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s_sb_empty: got 0 entries expected 1", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_sb_taken"}, 64'(pred_taken), 64'(e.t));
      check({name, "_sb_index"}, 64'(pred_index), 64'(e.i));
      check({name, "_sb_bcnt"},  64'(branch_cnt), 64'(e.b));
      check({name, "_sb_mcnt"},  64'(mispred_cnt), 64'(e.m));
      check({name, "_sb_bcnt4"}, 64'(branch_cnt_s), 64'(e.bs));
      check({name, "_sb_mcnt4"}, 64'(mispred_cnt_s), 64'(e.ms));
    end
    if (v.chk) begin
`ifndef BP_GSHARE_EN
      check({name, "_taken"}, 64'(pred_taken), 64'(v.e_t));
      check({name, "_index"}, 64'(pred_index), 64'(v.e_i));
`endif
      check({name, "_bcnt"}, 64'(branch_cnt), 64'(v.e_b));
      check({name, "_mcnt"}, 64'(mispred_cnt), 64'(v.e_m));
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; if_valid = 1'b0; if_pc = '0;
    upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0; upd_pred = 1'b0;

    // rst stall flush ifv pc | uv ui ut up | chk taken idx bcnt mcnt
    vecs.push_back(mk(1,0,0,0,64'h00, 0,0,0,0, 1, 0,0, 0,0));   // reset
    vecs.push_back(mk(0,0,0,1,64'h40, 0,0,0,0, 1, 0,0, 0,0));   // 0x40 aliases entry 0
    vecs.push_back(mk(0,0,0,0,64'h00, 1,3,1,0, 1, 0,0, 1,1));
    vecs.push_back(mk(0,0,0,0,64'h00, 1,3,1,1, 1, 0,0, 2,1));
    vecs.push_back(mk(0,0,0,1,64'h0C, 0,0,0,0, 1, 1,3, 2,1));   // entry 3 now 11
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,0,0,64'h00, 1,3,0,1, 1, 0,0, 3+k,2+k));
    vecs.push_back(mk(0,0,0,1,64'h0C, 0,0,0,0, 1, 0,3, 7,6));   // saturated low
    vecs.push_back(mk(0,0,0,1,64'h0C, 1,3,1,0, 1, 0,3, 8,7));   // 00 -> 01
    vecs.push_back(mk(0,0,0,1,64'h0C, 0,0,0,0, 1, 0,3, 8,7));   // proves it was 00
    vecs.push_back(mk(0,0,0,1,64'h14, 1,5,1,1, 1, 0,5, 9,7));   // no bypass
    vecs.push_back(mk(0,0,0,1,64'h14, 0,0,0,0, 1, 1,5, 9,7));   // new value visible
    vecs.push_back(mk(0,0,0,0,64'h00, 1,3,1,1, 1, 0,0, 10,7));
    vecs.push_back(mk(0,0,0,1,64'h0C, 0,0,0,0, 1, 1,3, 10,7));  // load 1/3
    vecs.push_back(mk(0,1,0,1,64'h00, 0,0,0,0, 1, 1,3, 10,7));  // stall holds
    vecs.push_back(mk(0,1,1,1,64'h0C, 1,3,0,1, 1, 0,0, 11,8));  // flush wins, trains
    vecs.push_back(mk(0,0,0,1,64'h0C, 0,0,0,0, 1, 0,3, 11,8));  // entry 3 decremented
    vecs.push_back(mk(0,0,0,0,64'h14, 0,0,0,0, 1, 0,5, 11,8));  // invalid fetch
    vecs.push_back(mk(1,0,0,1,64'h0C, 1,5,1,0, 1, 0,0, 0,0));   // rst beats update
    vecs.push_back(mk(0,0,0,0,64'h00, 1,1,1,1, 1, 0,0, 1,0));
    vecs.push_back(mk(0,0,0,0,64'h00, 1,1,0,1, 1, 0,0, 2,1));
    vecs.push_back(mk(0,0,0,0,64'h00, 1,1,1,1, 1, 0,0, 3,1));
    vecs.push_back(mk(0,0,0,1,64'h14, 0,0,0,0, 1, 0,5, 3,1));   // entry 5 back to 01

    foreach (vecs[n]) run_vec(vecs[n], $sformatf("row%0d", n));

    // Statistics saturation: 17 mispredicted updates after reset.
    run_vec(mk(1,0,0,0,64'h00, 0,0,0,0, 0, 0,0, 0,0), "sat_rst");
    for (int k = 0; k < 17; k++)
      run_vec(mk(0,0,0,0,64'h00, 1,2,1,0, 0, 0,0, 0,0), $sformatf("sat%0d", k));
    check("sat_bcnt4", 64'(branch_cnt_s), 64'd15);
    check("sat_mcnt4", 64'(mispred_cnt_s), 64'd15);
    check("sat_bcnt32", 64'(branch_cnt), 64'd17);
    check("sat_mcnt32", 64'(mispred_cnt), 64'd17);
    run_vec(mk(0,0,0,1,64'h08, 0,0,0,0, 1, 1,2, 17,17), "sat_lookup");

`ifdef BP_GSHARE_EN
    // History 1,0,1 gives GHR=0101, so PC 0 looks up entry 5.
    run_vec(mk(1,0,0,0,64'h00, 0,0,0,0, 0, 0,0, 0,0), "gs_rst");
    run_vec(mk(0,0,0,0,64'h00, 1,0,1,1, 0, 0,0, 0,0), "gs_u0");
    run_vec(mk(0,0,0,0,64'h00, 1,0,0,0, 0, 0,0, 0,0), "gs_u1");
    run_vec(mk(0,0,0,0,64'h00, 1,0,1,1, 0, 0,0, 0,0), "gs_u2");
    run_vec(mk(0,0,0,1,64'h00, 0,0,0,0, 0, 0,0, 0,0), "gs_look");
    check("gs_index5", 64'(pred_index), 64'd5);
    run_vec(mk(1,0,0,0,64'h00, 0,0,0,0, 0, 0,0, 0,0), "gs_rst2");
    run_vec(mk(0,0,0,1,64'h00, 0,0,0,0, 0, 0,0, 0,0), "gs_look2");
    check("gs_index0", 64'(pred_index), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
